// File: rtl/axis_pkg.sv
// Shared constants, FSM state type and width helpers for the vector adder.
package axis_pkg;

  localparam logic MODE_PAIR = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  // Widest lane arithmetic the helpers handle (ACC_W+1 must not exceed it).
  localparam int MAX_W = 64;

  typedef enum logic {ST_IDLE, ST_ACCUM} state_e;

  // Sign-extend the low w bits of v to MAX_W bits.
  function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) r[i] = (i < w) ? v[i] : v[w-1];
    return r;
  endfunction

  // 1 when the sign-extended value v does not fit a w-bit signed range.
  function automatic logic ovf_chk(input logic [MAX_W-1:0] v, input int w);
    return v != sext(v, w);
  endfunction

  // Fit v into w signed bits: clamp to the bound when sat, else keep the low bits.
  function automatic logic [MAX_W-1:0] sat_to(input logic [MAX_W-1:0] v, input int w,
                                              input logic sat);
    logic [MAX_W-1:0] lo;
    lo = {MAX_W{1'b1}} << (w - 1);
    if (v == sext(v, w)) return v;
    if (sat) return v[MAX_W-1] ? lo : ~lo;
    return sext(v, w);
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry FIFO with registered not-full ready; keeps 1 beat/cycle under backpressure.
module axis_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic         rdy_q, rdy_d;
  logic         push, pop;

  assign push    = s_valid & rdy_q;
  assign pop     = m_ready & (cnt_q != 2'd0);
  assign s_ready = rdy_q;
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = head_q;

  // Occupancy and entry update; head is always the oldest entry.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = s_data;
        else               tail_d = s_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) head_d = s_data;
        else begin
          head_d = tail_q;
          tail_d = s_data;
        end
      end
      default: ;
    endcase
    rdy_d = (cnt_d != 2'd2);
  end

  // Buffer state; ready comes up on the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      rdy_q  <= rdy_d;
    end
  end

endmodule

// File: rtl/axis_vec_adder.sv
// Multi-lane signed adder: pairwise sums or per-packet accumulation, AXI-stream both sides.
module axis_vec_adder
  import axis_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int LANES  = 4,
  parameter int ACC_W  = 24,  // must be >= DATA_W+1
  parameter int SAT    = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [LANES*DATA_W-1:0] s_a,
  input  logic [LANES*DATA_W-1:0] s_b,
  input  logic                    s_last,
  input  logic                    mode,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [LANES*ACC_W-1:0]  m_sum,
  output logic                    m_last,
  output logic [LANES-1:0]        m_ovf
);

  localparam int SW = ACC_W + 1;
  localparam int PW = LANES + LANES*ACC_W;

  state_e                      state_q, state_d;
  logic [LANES-1:0][ACC_W-1:0] acc_q, acc_d, lane_res;
  logic [LANES-1:0]            stk_q, stk_d, lane_ovf, push_ovf;
  logic                        s_xfer, push;
  logic [PW-1:0]               m_data;

  assign s_xfer = s_valid & s_ready;

  // Per-lane a+b(+acc) evaluated at ACC_W+1 bits, then wrapped or clamped to ACC_W.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [MAX_W-1:0] acc_x, sum_x;
    assign acc_x = (state_q == ST_ACCUM) ? sext(MAX_W'(acc_q[i]), ACC_W) : '0;
    assign sum_x = sext(MAX_W'(SW'(sext(MAX_W'(s_a[i*DATA_W +: DATA_W]), DATA_W)
                                 + sext(MAX_W'(s_b[i*DATA_W +: DATA_W]), DATA_W)
                                 + acc_x)), SW);
    assign lane_ovf[i] = ovf_chk(sum_x, ACC_W);
    assign lane_res[i] = ACC_W'(sat_to(sum_x, ACC_W, SAT != 0));
  end

  // Packet FSM: decides push vs. accumulate and carries the sticky overflow.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    stk_d    = stk_q;
    push     = 1'b0;
    push_ovf = (state_q == ST_ACCUM) ? (stk_q | lane_ovf) : lane_ovf;
    if (s_xfer) begin
      if (state_q == ST_IDLE) begin
        if (mode == MODE_PAIR || s_last) begin
          push = 1'b1;
        end else begin
          acc_d   = lane_res;
          stk_d   = lane_ovf;
          state_d = ST_ACCUM;
        end
      end else if (s_last) begin
        push    = 1'b1;
        acc_d   = '0;
        stk_d   = '0;
        state_d = ST_IDLE;
      end else begin
        acc_d = lane_res;
        stk_d = stk_q | lane_ovf;
      end
    end
  end

  // Accumulator, sticky overflow and FSM state; reset discards any open packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      stk_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      stk_q   <= stk_d;
    end
  end

  axis_skid2 #(.W(PW)) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .s_valid (push),
    .s_ready (s_ready),
    .s_data  ({push_ovf, lane_res}),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  // Every emitted beat closes a packet.
  assign m_last = m_valid;
  assign m_ovf  = m_data[PW-1 -: LANES];
  assign m_sum  = m_data[LANES*ACC_W-1:0];

endmodule
